serial_borrow_subtractor: RTL
=============================

Name: serial_borrow_subtractor

Overview:
- Multi-cycle wide unsigned subtractor; the inverse-direction companion to the team's ripple-carry adder datapath.
- Computes oDiff = iA - iB - iBorrow, one SLICE_WIDTH slice per clock, with a registered borrow rippling between slices.
- Sits behind valid/ready handshakes so wide-operand arithmetic (ALU, bignum, crypto paths) can trade latency for area.

Parameters:
- OPERAND_WIDTH, 64: width of iA, iB, oDiff in bits.
- SLICE_WIDTH, 16: bits subtracted per clock. OPERAND_WIDTH must be an integer multiple of SLICE_WIDTH; any other value is an elaboration error.
- NSLICES (localparam) = OPERAND_WIDTH/SLICE_WIDTH. A value of 1 is legal.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  synchronous reset, active-high.
- iA  input  OPERAND_WIDTH  minuend, unsigned.
- iB  input  OPERAND_WIDTH  subtrahend, unsigned.
- iBorrow  input  1  borrow-in to slice 0.
- iValid  input  1  operands valid.
- oReady  output  1  block can accept operands.
- oDiff  output  OPERAND_WIDTH  difference.
- oBorrow  output  1  borrow-out of the top slice.
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts result.

Behaviour:
- Clock and reset: single clock iClk; iRst is synchronous, active-high.
- Reset: state=IDLE, oReady=1, oValid=0, oDiff=0, oBorrow=0, slice counter=0, internal operand and borrow registers=0.
- State IDLE (oReady=1):
  - On iValid&&oReady, capture iA, iB and iBorrow, clear the counter, go to RUN.
  - Inputs are sampled only on this accept edge; later changes to them are ignored.
- State RUN (oReady=0, oValid=0):
  - Each clock computes {borrow,d} = A_slice[cnt] - B_slice[cnt] - borrow using SLICE_WIDTH+1-bit arithmetic.
  - Write d into oDiff slice cnt (LSB slice first), register the new borrow, increment cnt.
  - After slice NSLICES-1 is processed, go to DONE.
- State DONE (oValid=1, oReady=0):
  - oDiff and oBorrow are held stable.
  - On iReady, go to IDLE; oReady=1 and oValid=0 from the next cycle.
  - Without iReady, hold indefinitely. iValid is ignored.
- Latency: oValid rises exactly NSLICES clock edges after the accept edge; throughput is one operation per NSLICES+2 cycles minimum.
- No accept in the same cycle as a result handoff: oReady is 0 while DONE.
- oBorrow=1 iff A < B + iBorrow (unsigned).
- Wrap-around: the result is modulo 2^OPERAND_WIDTH.
- Simultaneous events: iValid in RUN/DONE is ignored, and the upstream must hold it. iRst overrides every handshake.
- Reset mid-operation: the partial result is discarded and all outputs return to reset values on the next cycle.
- oDiff is fully registered and glitch-free. Intermediate slices are visible during RUN, but only the value qualified by oValid is meaningful.

Optional Feature:
- Macro: SUB_SIGNED_OVF_EN.
- Defined: adds output port oOverflow (1 bit), registered and valid with oValid.
  - oOverflow = signed two's-complement overflow of the full-width operation: sign(A)!=sign(B) and sign(result)!=sign(A).
  - Reset value 0; held in DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (OPERAND_WIDTH=64, SLICE_WIDTH=16, NSLICES=4):
1. A=5, B=3, iBorrow=0 -> oDiff=2, oBorrow=0, oValid high exactly 4 edges after accept. Repeat with iBorrow=1 -> oDiff=1.
2. A=0, B=1 -> oDiff=64'hFFFF_FFFF_FFFF_FFFF, oBorrow=1 (borrow ripples through all 4 slices).
3. A=64'h0001_0000_0000_0000, B=1 -> oDiff=64'h0000_FFFF_FFFF_FFFF, oBorrow=0 (cross-slice borrow).
4. Backpressure: iReady=0 for 10 cycles in DONE with iValid pulsing -> oDiff, oBorrow and oValid stable, oReady=0, no new capture. Raise iReady -> oReady=1 next cycle; the next operation is correct.
5. Assert iRst during RUN at cnt=2 -> next cycle oValid=0, oReady=1, oDiff=0, oBorrow=0. The following op A=100, B=40 -> oDiff=60.
6. With SUB_SIGNED_OVF_EN: A=64'h8000_0000_0000_0000, B=1 -> oOverflow=1, oDiff=64'h7FFF_FFFF_FFFF_FFFF; A=5, B=3 -> oOverflow=0. Build without the macro -> compiles, no oOverflow port.

Source files
------------

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle unsigned subtractor: one SLICE_WIDTH slice per clock with a registered rippling borrow.
// Optional macro SUB_SIGNED_OVF_EN adds a registered signed-overflow flag (oOverflow).
module serial_borrow_subtractor #(
  parameter int OPERAND_WIDTH = 64,
  parameter int SLICE_WIDTH   = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iBorrow,
  input  logic                     iValid,
  output logic                     oReady,
  output logic [OPERAND_WIDTH-1:0] oDiff,
  output logic                     oBorrow,
  output logic                     oValid,
  input  logic                     iReady
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic                     oOverflow
`endif
);

  localparam int NSLICES = OPERAND_WIDTH / SLICE_WIDTH;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  generate
    if ((SLICE_WIDTH < 1) || (OPERAND_WIDTH % SLICE_WIDTH != 0)) begin : g_bad_width
      $error("OPERAND_WIDTH must be a positive integer multiple of SLICE_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0] a_q, a_d;
  logic [OPERAND_WIDTH-1:0] b_q, b_d;
  logic                     borrow_q, borrow_d;
  logic [OPERAND_WIDTH-1:0] diff_q, diff_d;
  logic                     borrow_out_q, borrow_out_d;
`ifdef SUB_SIGNED_OVF_EN
  logic                     ovf_q, ovf_d;
`endif

  logic [SLICE_WIDTH-1:0]   slice_a, slice_b, slice_diff;
  logic                     slice_borrow;
  int                       slice_base;

  // Current slice arithmetic: the extra MSB of the widened difference is the borrow-out.
  always_comb begin
    slice_base = int'(cnt_q) * SLICE_WIDTH;
    slice_a    = a_q[slice_base +: SLICE_WIDTH];
    slice_b    = b_q[slice_base +: SLICE_WIDTH];
    {slice_borrow, slice_diff} = {1'b0, slice_a} - {1'b0, slice_b}
                               - {{SLICE_WIDTH{1'b0}}, borrow_q};
  end

  // NOTE: every variable gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d        = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          a_d      = iA;
          b_d      = iB;
          borrow_d = iBorrow;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[slice_base +: SLICE_WIDTH] = slice_diff;
        borrow_d = slice_borrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          borrow_out_d = slice_borrow;
`ifdef SUB_SIGNED_OVF_EN
          // Top slice holds the result sign bit.
          ovf_d = (a_q[OPERAND_WIDTH-1] ^ b_q[OPERAND_WIDTH-1])
                & (slice_diff[SLICE_WIDTH-1] ^ a_q[OPERAND_WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and every register, datapath included, is reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign oReady  = (state_q == IDLE);
  assign oValid  = (state_q == DONE);
  assign oDiff   = diff_q;
  assign oBorrow = borrow_out_q;
`ifdef SUB_SIGNED_OVF_EN
  assign oOverflow = ovf_q;
`endif

endmodule
